// File: rtl/player_hit_detector.sv
// ---------------------------------------------------------------------------
// player_hit_detector
//
// Per-frame collision stage that feeds the UI runtime. It runs on the
// calculation clock next to the VGA pixel scan. It counts the visible pixels
// where the player sprite and any attack sprite overlap. At each frame
// boundary (frame_tick) it judges hit / no-hit. After the last hit frame it
// keeps is_trigger_player high for HOLD_FRAMES frames, so the slow
// centisecond-clocked health logic cannot miss it.
//
// Optional feature macro: PLAYER_HIT_STATS_EN
//   When defined, the total_hit_frames output exists. It is a 16-bit
//   saturating count of hit_frame pulses, for the on-board debug display,
//   and only reset clears it.
//
// Parameters:
//   COUNT_WIDTH   - width of the overlap pixel counter (saturating)
//   HIT_THRESHOLD - minimum overlap pixels in one frame to register a hit
//   HOLD_FRAMES   - frames is_trigger_player stays high after a hit frame
//   HOLD_WIDTH    - width of the hold counter (HOLD_FRAMES < 2^HOLD_WIDTH)
//
// Ports:
//   clk_calculation    in   calculation clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   enable             in   game active; low forces the block idle
//   frame_tick         in   one-cycle pulse at end of visible frame
//   pixel_valid        in   x,y inside the visible area
//   player_signal      in   player sprite pixel at x,y
//   attack_signal      in   any attack/bullet pixel at x,y
//   is_trigger_player  out  registered hit level (held for HOLD_FRAMES)
//   hit_frame          out  one-cycle pulse when a frame is judged a hit
//   last_overlap_count out  overlap count of the last completed frame
//   total_hit_frames   out  [PLAYER_HIT_STATS_EN only] hit frame counter
// ---------------------------------------------------------------------------
module player_hit_detector #(
  parameter int unsigned COUNT_WIDTH   = 12,
  parameter int unsigned HIT_THRESHOLD = 4,
  parameter int unsigned HOLD_FRAMES   = 3,
  parameter int unsigned HOLD_WIDTH    = 4
) (
  input  logic                   clk_calculation,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic                   pixel_valid,
  input  logic                   player_signal,
  input  logic                   attack_signal,
  output logic                   is_trigger_player,
  output logic                   hit_frame,
  output logic [COUNT_WIDTH-1:0] last_overlap_count
`ifdef PLAYER_HIT_STATS_EN
  ,
  output logic [15:0]            total_hit_frames
`endif
);

  localparam logic [COUNT_WIDTH-1:0] C_THRESHOLD = COUNT_WIDTH'(HIT_THRESHOLD);
  localparam logic [HOLD_WIDTH-1:0]  C_HOLD      = HOLD_WIDTH'(HOLD_FRAMES);
  localparam logic [HOLD_WIDTH-1:0]  C_HOLD_ONE  = HOLD_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [COUNT_WIDTH-1:0] r_overlap_cnt;
  logic [COUNT_WIDTH-1:0] w_overlap_nxt;
  logic [HOLD_WIDTH-1:0]  r_hold_cnt;
  logic [HOLD_WIDTH-1:0]  w_hold_nxt;
  logic                   r_trigger;
  logic                   w_trigger_nxt;
  logic                   r_hit_frame;
  logic                   w_hit_frame_nxt;
  logic [COUNT_WIDTH-1:0] r_last_cnt;
  logic [COUNT_WIDTH-1:0] w_last_nxt;

  logic                   w_overlap_px;
  logic                   w_cnt_full;
  logic                   w_hit;

  // A pixel that coincides with frame_tick belongs to neither frame, so it
  // is never counted.
  assign w_overlap_px = pixel_valid & player_signal & attack_signal & ~frame_tick;
  assign w_cnt_full   = &r_overlap_cnt;
  assign w_hit        = (r_overlap_cnt >= C_THRESHOLD);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_calculation or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_overlap_cnt <= '0;
      r_hold_cnt    <= '0;
      r_trigger     <= 1'b0;
      r_hit_frame   <= 1'b0;
      r_last_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_overlap_cnt <= w_overlap_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_trigger     <= w_trigger_nxt;
      r_hit_frame   <= w_hit_frame_nxt;
      r_last_cnt    <= w_last_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_overlap_nxt   = r_overlap_cnt;
    w_hold_nxt      = r_hold_cnt;
    w_trigger_nxt   = r_trigger;
    w_hit_frame_nxt = 1'b0;
    w_last_nxt      = r_last_cnt;

    if (!enable) begin
      // Disabling from any state discards the partial frame and drops the
      // hit level on the very next edge.
      w_state_nxt   = ST_IDLE;
      w_overlap_nxt = '0;
      w_hold_nxt    = '0;
      w_trigger_nxt = 1'b0;
      w_last_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ALIGN;
        end

        ST_ALIGN: begin
          // The first tick after enable only marks a frame start. Any
          // overlap seen before it belongs to a partial frame.
          if (frame_tick) begin
            w_state_nxt   = ST_SCAN;
            w_overlap_nxt = '0;
          end
        end

        ST_SCAN: begin
          if (frame_tick) begin
            w_last_nxt    = r_overlap_cnt;
            w_overlap_nxt = '0;
            if (w_hit) begin
              // A retrigger reloads the hold. It never extends past a full
              // HOLD_FRAMES.
              w_hold_nxt      = C_HOLD;
              w_trigger_nxt   = 1'b1;
              w_hit_frame_nxt = 1'b1;
            end else if (r_hold_cnt > C_HOLD_ONE) begin
              w_hold_nxt = r_hold_cnt - C_HOLD_ONE;
            end else begin
              w_hold_nxt    = '0;
              w_trigger_nxt = 1'b0;
            end
          end else if (w_overlap_px && !w_cnt_full) begin
            w_overlap_nxt = r_overlap_cnt + COUNT_WIDTH'(1);
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign is_trigger_player  = r_trigger;
  assign hit_frame          = r_hit_frame;
  assign last_overlap_count = r_last_cnt;

`ifdef PLAYER_HIT_STATS_EN
  // -------------------------------------------------------------------------
  // Debug statistics: lifetime hit frames. Only reset clears this counter,
  // so it survives enable toggles between games.
  // -------------------------------------------------------------------------
  logic [15:0] r_total_hits;

  always_ff @(posedge clk_calculation or negedge reset_n) begin
    if (!reset_n) begin
      r_total_hits <= '0;
    end else if (r_hit_frame && (r_total_hits != '1)) begin
      r_total_hits <= r_total_hits + 16'd1;
    end
  end

  assign total_hit_frames = r_total_hits;
`endif

endmodule

// File: tb/tb_player_hit_detector.sv
module tb_player_hit_detector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic frame_tick = 1'b0;
  logic pixel_valid = 1'b0;
  logic player_signal = 1'b0;
  logic attack_signal = 1'b0;

  logic        trig0, hf0, trig1, hf1;
  logic [11:0] last0;
  logic [2:0]  last1;
`ifdef PLAYER_HIT_STATS_EN
  logic [15:0] tot0, tot1;
`endif

  always #5 clk = ~clk;

  // Default configuration
  player_hit_detector dut0 (
    .clk_calculation   (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .frame_tick        (frame_tick),
    .pixel_valid       (pixel_valid),
    .player_signal     (player_signal),
    .attack_signal     (attack_signal),
    .is_trigger_player (trig0),
    .hit_frame         (hf0),
    .last_overlap_count(last0)
`ifdef PLAYER_HIT_STATS_EN
    ,
    .total_hit_frames  (tot0)
`endif
  );

  // Narrow counter, short hold: exercises saturation and a different hold
  player_hit_detector #(
    .COUNT_WIDTH  (3),
    .HIT_THRESHOLD(4),
    .HOLD_FRAMES  (2),
    .HOLD_WIDTH   (2)
  ) dut1 (
    .clk_calculation   (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .frame_tick        (frame_tick),
    .pixel_valid       (pixel_valid),
    .player_signal     (player_signal),
    .attack_signal     (attack_signal),
    .is_trigger_player (trig1),
    .hit_frame         (hf1),
    .last_overlap_count(last1)
`ifdef PLAYER_HIT_STATS_EN
    ,
    .total_hit_frames  (tot1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for first tick, 2 scanning frames.
  // since: judged frames since the last hit frame (1000 = none); the level is
  // high while fewer than HOLD judged frames have passed since a hit.
  int unsigned cmax [2] = '{4095, 7};
  int unsigned thr  [2] = '{4, 4};
  int unsigned hold [2] = '{3, 2};
  int          ph   [2];
  int unsigned pix  [2];
  int unsigned since[2];
  int unsigned e_last[2];
  bit          e_trig[2];
  bit          e_hf  [2];
  int unsigned e_tot [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; pix[k] = 0; since[k] = 1000;
      e_last[k] = 0; e_trig[k] = 0; e_hf[k] = 0; e_tot[k] = 0;
    end
  endtask

  task automatic model_step();
    int unsigned sat;
    for (int k = 0; k < 2; k++) begin
      if (e_hf[k] && e_tot[k] < 65535) e_tot[k]++;
      e_hf[k] = 0;
      if (!enable) begin
        ph[k] = 0; pix[k] = 0; since[k] = 1000; e_trig[k] = 0; e_last[k] = 0;
      end else if (ph[k] == 0) begin
        ph[k] = 1;
      end else if (ph[k] == 1) begin
        if (frame_tick) begin ph[k] = 2; pix[k] = 0; end
      end else begin
        if (frame_tick) begin
          sat = (pix[k] > cmax[k]) ? cmax[k] : pix[k];
          e_last[k] = sat;
          if (sat >= thr[k]) begin
            since[k] = 0; e_hf[k] = 1;
          end else if (since[k] < 1000) begin
            since[k]++;
          end
          e_trig[k] = (since[k] < hold[k]);
          pix[k] = 0;
        end else if (pixel_valid && player_signal && attack_signal) begin
          pix[k]++;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("dut0.trig", 32'(trig0), 32'(e_trig[0]));
    check("dut0.hit_frame", 32'(hf0), 32'(e_hf[0]));
    check("dut0.last", 32'(last0), e_last[0]);
    check("dut1.trig", 32'(trig1), 32'(e_trig[1]));
    check("dut1.hit_frame", 32'(hf1), 32'(e_hf[1]));
    check("dut1.last", 32'(last1), e_last[1]);
`ifdef PLAYER_HIT_STATS_EN
    check("dut0.total", 32'(tot0), e_tot[0]);
    check("dut1.total", 32'(tot1), e_tot[1]);
`endif
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic cyc(input bit en, input bit tk, input bit pv, input bit ps, input bit pa);
    enable = en; frame_tick = tk; pixel_valid = pv;
    player_signal = ps; attack_signal = pa;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic overlap_px(); cyc(1, 0, 1, 1, 1); endtask
  task automatic empty_px();   cyc(1, 0, 1, 1, 0); endtask
  task automatic tick();       cyc(1, 1, 0, 0, 0); endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) overlap_px();
    empty_px();
    tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    compare_all();
  endtask

  initial begin
    // Reset with enable high: everything stays zero.
    enable = 1;
    do_reset();
    check("rst.trig", 32'(trig0), 0);
    check("rst.hf", 32'(hf0), 0);
    check("rst.last", 32'(last0), 0);

    // Released but disabled: overlap and ticks are ignored.
    @(negedge clk); reset_n = 1;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 0);
    check("dis.trig", 32'(trig0), 0);
    check("dis.last", 32'(last0), 0);

    // Enable, align, then threshold boundary.
    empty_px();
    overlap_px(); overlap_px();
    tick();                                   // align only
    check("align.hf", 32'(hf0), 0);
    frame(3);
    check("th3.trig", 32'(trig0), 0);
    check("th3.last", 32'(last0), 3);
    frame(4);
    check("th4.hf", 32'(hf0), 1);
    check("th4.trig", 32'(trig0), 1);
    check("th4.last", 32'(last0), 4);
    empty_px();
    check("th4.hf_clear", 32'(hf0), 0);

    // Hold: three empty frames.
    frame(0); check("hold1", 32'(trig0), 1);
    frame(0); check("hold2", 32'(trig0), 1);
    frame(0); check("hold3", 32'(trig0), 0);

    // Retrigger: hit, empty, hit, then three empty frames.
    frame(5); frame(0); frame(6);
    check("retrig.hf", 32'(hf0), 1);
    frame(0); frame(0);
    check("retrig.hold", 32'(trig0), 1);
    frame(0);
    check("retrig.drop", 32'(trig0), 0);

    // Overlap pixel on the tick cycle is not counted.
    for (int i = 0; i < 3; i++) overlap_px();
    cyc(1, 1, 1, 1, 1);
    check("tickx.last", 32'(last0), 3);
    check("tickx.hf", 32'(hf0), 0);

    // Saturation of the narrow instance.
    frame(10);
    check("sat.last1", 32'(last1), 7);
    check("sat.last0", 32'(last0), 10);
    check("sat.hf1", 32'(hf1), 1);

    // Back-to-back ticks: second frame counts 0.
    for (int i = 0; i < 5; i++) overlap_px();
    tick(); tick();
    check("b2b.last", 32'(last0), 0);

    // Enable drop mid-hold, then re-enable: first tick only aligns.
    frame(4);
    check("drop.pre", 32'(trig0), 1);
    cyc(0, 0, 1, 1, 1);
    check("drop.trig", 32'(trig0), 0);
    check("drop.last", 32'(last0), 0);
    for (int i = 0; i < 6; i++) overlap_px();
    tick();
    check("realign.hf", 32'(hf0), 0);
    check("realign.trig", 32'(trig0), 0);
    frame(0);
    check("realign.last", 32'(last0), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1));
    end

    // Mid-frame reset discards everything; stats also clear.
    for (int i = 0; i < 3; i++) overlap_px();
    @(negedge clk);
    do_reset();
    @(negedge clk); reset_n = 1;
    for (int i = 0; i < 20; i++)
      cyc(1, ($urandom_range(0, 5) == 0), 1, 1, ($urandom_range(0, 1) == 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_hit_detector.md
Name: player_hit_detector

Overview:
- Per-frame collision stage directly upstream of the UI runtime; produces its is_trigger_player level.
- Runs on the calculation clock alongside the VGA pixel scan and counts pixels where the player sprite and any attack sprite overlap.
- At each frame boundary it decides hit / no-hit, then holds is_trigger_player high for a programmable number of frames. The hold lets the slow centisecond-clocked health logic sample the hit reliably.

Parameters:
- COUNT_WIDTH, 12, width of the overlap pixel counter; counter saturates at 2^COUNT_WIDTH-1.
- HIT_THRESHOLD, 4, minimum overlap pixels in one frame to register a hit; legal range 1..2^COUNT_WIDTH-1.
- HOLD_FRAMES, 3, frames is_trigger_player stays high after the last hit frame; legal range ≥1.
- HOLD_WIDTH, 4, width of the hold counter; must satisfy HOLD_FRAMES < 2^HOLD_WIDTH.

Ports:
- clk_calculation  input  1  system calculation clock; all state on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  game active; low forces the block idle.
- frame_tick  input  1  one-cycle pulse marking the end of the visible frame (start of vblank).
- pixel_valid  input  1  high while x,y are inside the visible area.
- player_signal  input  1  player sprite pixel at current x,y.
- attack_signal  input  1  any attack/bullet pixel at current x,y.
- is_trigger_player  output  1  registered hit level, consumed by the UI runtime.
- hit_frame  output  1  one-cycle pulse when a frame is judged a hit.
- last_overlap_count  output  COUNT_WIDTH  overlap count of the most recently completed frame.

Behaviour:
- Reset (reset_n low, async): state=IDLE; overlap_cnt=0; hold_cnt=0; is_trigger_player=0; hit_frame=0; last_overlap_count=0.
- States:
  - IDLE: enable low.
  - ALIGN: enabled; waiting for the first frame_tick.
  - SCAN: accumulating overlap.
- Transitions:
  - IDLE→ALIGN when enable=1.
  - ALIGN→SCAN on frame_tick. That tick performs no evaluation and clears overlap_cnt.
  - Any state→IDLE when enable=0, on the next edge. Entering IDLE clears overlap_cnt, hold_cnt, is_trigger_player and last_overlap_count.
- Accumulate, SCAN only: when pixel_valid & player_signal & attack_signal & !frame_tick, overlap_cnt increments by 1, saturating at all-ones (no wrap).
- Pixels coinciding with frame_tick are never counted.
- Evaluation on a frame_tick cycle in SCAN, all registered on that edge:
  - last_overlap_count ← overlap_cnt.
  - overlap_cnt ← 0.
  - hit = (overlap_cnt ≥ HIT_THRESHOLD).
  - If hit: hold_cnt ← HOLD_FRAMES; is_trigger_player ← 1; hit_frame ← 1.
  - Else if hold_cnt > 1: hold_cnt ← hold_cnt-1; is_trigger_player stays 1.
  - Else: hold_cnt ← 0; is_trigger_player ← 0.
- Latency: is_trigger_player and hit_frame rise one cycle after the judging frame_tick.
- hit_frame clears the following cycle.
- A hit during the hold reloads hold_cnt (retrigger); it does not add to it.
- is_trigger_player only changes on frame_tick edges or on entering IDLE/reset. It never glitches mid-frame.
- Reset or enable drop mid-frame discards the partial count.
- Back-to-back frame_tick (two consecutive cycles): the second evaluates a count of 0.

Optional Feature:
- Macro: PLAYER_HIT_STATS_EN.
- Defined: adds output total_hit_frames [15:0].
  - Increments on every hit_frame pulse, saturating at 16'hFFFF.
  - Cleared by reset only; enable does not clear it.
  - For the on-board debug display.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: reset_n=0 with enable=1 → all outputs 0; release with enable=0, drive overlap pixels and ticks → outputs stay 0.
- Threshold boundary, defaults: align tick, then 3 overlap pixels + tick → no hit, last_overlap_count=3. Then 4 pixels + tick → hit_frame pulse one cycle after the tick, is_trigger_player=1, last_overlap_count=4.
- Hold: after a single hit frame, 3 empty frames → is_trigger_player stays 1 through the 2nd empty tick and drops one cycle after the 3rd empty tick.
- Retrigger: hit, empty, hit, then 3 empty frames → is_trigger_player stays high continuously until the 3rd empty tick after the second hit.
- Tick exclusion and saturation:
  - With COUNT_WIDTH=3, 10 overlap pixels → last_overlap_count=7.
  - An overlap pixel on the frame_tick cycle is not counted.
- Enable drop: hit asserted, enable=0 mid-hold → is_trigger_player=0 next edge. Re-enable → first tick only aligns; no hit even if overlap occurred before it.
